// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the memory port arbiter
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, HOLD_IF, HOLD_LS, WAIT_IF, WAIT_LS} memArbState_t;
  typedef enum logic {OWN_IF, OWN_LS} memOwner_t;
  localparam int MEM_W = 32;
endpackage

// File: rtl/mem_port_arb.sv
// mem_port_arb: serializes fetch and load/store requests onto one memory port, one transaction in flight
module mem_port_arb
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifReq,
  input  logic [MEM_W-1:0] ifAddr,
  output logic             ifGnt,
  output logic             ifRvalid,
  output logic [MEM_W-1:0] ifRdata,
  input  logic             lsReq,
  input  logic             lsWe,
  input  logic [3:0]       lsBe,
  input  logic [MEM_W-1:0] lsAddr,
  input  logic [MEM_W-1:0] lsWdata,
  output logic             lsGnt,
  output logic             lsRvalid,
  output logic [MEM_W-1:0] lsRdata,
  output logic             memReq,
  output logic             memWe,
  output logic [3:0]       memBe,
  output logic [MEM_W-1:0] memAddr,
  output logic [MEM_W-1:0] memWdata,
  input  logic             memGnt,
  input  logic             memRvalid,
  input  logic [MEM_W-1:0] memRdata
);
  memArbState_t r_state, w_next;
  memOwner_t    w_owner;
  logic [3:0]   r_starve_cnt;
  logic         w_req, w_ls;
  assign w_owner = (r_state == IDLE)
    ? ((lsReq && !(ifReq && r_starve_cnt == 4'(STARVE_MAX))) ? OWN_LS : OWN_IF)
    : ((r_state == HOLD_LS || r_state == WAIT_LS) ? OWN_LS : OWN_IF);
  assign w_req = !rst && ((r_state == IDLE) ? (ifReq || lsReq) : (r_state == HOLD_IF || r_state == HOLD_LS));
  // state register; reset abandons any outstanding response
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state: request goes to HOLD or WAIT for its owner, a response in WAIT returns to IDLE
  always_comb begin
    w_next = r_state;
    if (w_req) w_next = memGnt ? ((w_owner == OWN_LS) ? WAIT_LS : WAIT_IF)
                               : ((w_owner == OWN_LS) ? HOLD_LS : HOLD_IF);
    else if ((r_state == WAIT_IF || r_state == WAIT_LS) && memRvalid) w_next = IDLE;
  end
  // output mux: owner's fields on the memory channel, responses routed only to the waiting owner
  always_comb begin
    w_ls     = w_owner == OWN_LS;
    memReq   = w_req;
    memWe    = w_req && w_ls && lsWe;
    memBe    = w_req ? (w_ls ? lsBe : 4'hF) : 4'h0;
    memAddr  = w_req ? (w_ls ? lsAddr : ifAddr) : '0;
    memWdata = (w_req && w_ls) ? lsWdata : '0;
    ifGnt    = w_req && memGnt && !w_ls;
    lsGnt    = w_req && memGnt && w_ls;
    ifRvalid = !rst && r_state == WAIT_IF && memRvalid;
    lsRvalid = !rst && r_state == WAIT_LS && memRvalid;
    ifRdata  = ifRvalid ? memRdata : '0;
    lsRdata  = lsRvalid ? memRdata : '0;
  end
  // starvation counter: LS grants bypassing a pending fetch, saturating at STARVE_MAX
  always_ff @(posedge clk) begin
    if (rst || !ifReq || ifGnt) r_starve_cnt <= '0;
    else if (lsGnt && r_starve_cnt != 4'(STARVE_MAX)) r_starve_cnt <= r_starve_cnt + 4'd1;
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arb;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic rst;
  logic ifReq, ifGnt, ifRvalid;
  logic [31:0] ifAddr, ifRdata;
  logic lsReq, lsWe, lsGnt, lsRvalid;
  logic [3:0] lsBe;
  logic [31:0] lsAddr, lsWdata, lsRdata;
  logic memReq, memWe, memGnt, memRvalid;
  logic [3:0] memBe;
  logic [31:0] memAddr, memWdata, memRdata;
  int total = 0, bad = 0;
  int m_who = 0;
  bit m_granted = 0;
  int m_streak = 0;
  bit pend = 0;
  int e_who;
  bit e_req, e_we, e_ifg, e_lsg, e_ifv, e_lsv;
  logic [3:0] e_be;
  logic [31:0] e_addr, e_wdata;
  bit last_ifg = 0, last_lsg = 0;

  mem_port_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRvalid(ifRvalid), .ifRdata(ifRdata),
    .lsReq(lsReq), .lsWe(lsWe), .lsBe(lsBe), .lsAddr(lsAddr), .lsWdata(lsWdata),
    .lsGnt(lsGnt), .lsRvalid(lsRvalid), .lsRdata(lsRdata),
    .memReq(memReq), .memWe(memWe), .memBe(memBe), .memAddr(memAddr), .memWdata(memWdata),
    .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // who owns the port: the current transaction's requester, or the priority winner when free
  task automatic predict();
    e_who = m_who;
    if (e_who == 0) e_who = (lsReq && !(ifReq && m_streak == SM)) ? 2 : (ifReq ? 1 : 0);
    e_req   = !rst && e_who != 0 && !m_granted;
    e_we    = e_req && e_who == 2 && lsWe;
    e_be    = e_req ? ((e_who == 2) ? lsBe : 4'hF) : 4'h0;
    e_addr  = e_req ? ((e_who == 2) ? lsAddr : ifAddr) : 32'h0;
    e_wdata = (e_req && e_who == 2) ? lsWdata : 32'h0;
    e_ifg   = e_req && memGnt && e_who == 1;
    e_lsg   = e_req && memGnt && e_who == 2;
    e_ifv   = !rst && m_granted && e_who == 1 && memRvalid;
    e_lsv   = !rst && m_granted && e_who == 2 && memRvalid;
  endtask

  // one cycle: check outputs before the edge, then advance model and memory bookkeeping
  task automatic cyc();
    #1;
    predict();
    chk("memReq", memReq, e_req);
    chk("memWe", memWe, e_we);
    chk("memBe", memBe, e_be);
    chk("memAddr", memAddr, e_addr);
    chk("memWdata", memWdata, e_wdata);
    chk("ifGnt", ifGnt, e_ifg);
    chk("lsGnt", lsGnt, e_lsg);
    chk("ifRvalid", ifRvalid, e_ifv);
    chk("lsRvalid", lsRvalid, e_lsv);
    chk("ifRdata", ifRdata, e_ifv ? memRdata : 32'h0);
    chk("lsRdata", lsRdata, e_lsv ? memRdata : 32'h0);
    @(posedge clk);
    if (memRvalid) pend = 0;
    if (e_req && memGnt) pend = 1;
    if (rst) begin
      m_who = 0; m_granted = 0; m_streak = 0;
    end else begin
      if (!ifReq || e_ifg) m_streak = 0;
      else if (e_lsg && m_streak < SM) m_streak++;
      if (e_req) begin
        m_who = e_who; m_granted = memGnt;
      end else if (m_granted && memRvalid) begin
        m_who = 0; m_granted = 0;
      end
    end
    last_ifg = e_ifg;
    last_lsg = e_lsg;
    @(negedge clk);
  endtask

  initial begin
    int n_ls;
    bit got_if;
    rst = 1; ifReq = 1; ifAddr = 0; lsReq = 0; lsWe = 0; lsBe = 0; lsAddr = 0; lsWdata = 0;
    memGnt = 0; memRvalid = 0; memRdata = 0;
    @(negedge clk);
    #1;
    chk("rst_memReq", memReq, 0);
    chk("rst_ifGnt", ifGnt, 0);
    cyc(); cyc();
    rst = 0;
    #1;
    chk("post_rst_memReq", memReq, 1);
    chk("post_rst_memAddr", memAddr, 32'h0);
    cyc();
    memGnt = 1; cyc();
    ifReq = 0; memGnt = 0; memRvalid = 1; memRdata = 32'h0BAD_F00D; cyc();
    memRvalid = 0;
    // simultaneous requests: LS first, then IF
    ifReq = 1; ifAddr = 32'h100; lsReq = 1; lsWe = 0; lsBe = 4'hF; lsAddr = 32'h2000; memGnt = 1;
    #1;
    chk("both_lsGnt", lsGnt, 1);
    chk("both_ifGnt", ifGnt, 0);
    chk("both_addr", memAddr, 32'h2000);
    cyc();
    lsReq = 0; memGnt = 0; cyc();
    memRvalid = 1; memRdata = 32'hDEAD_BEEF;
    #1;
    chk("load_lsRvalid", lsRvalid, 1);
    chk("load_lsRdata", lsRdata, 32'hDEAD_BEEF);
    chk("load_ifRvalid", ifRvalid, 0);
    cyc();
    memRvalid = 0; memGnt = 1;
    #1;
    chk("if_next_gnt", ifGnt, 1);
    chk("if_next_addr", memAddr, 32'h100);
    cyc();
    ifReq = 0; memGnt = 0; memRvalid = 1; memRdata = 32'h1111_2222; cyc();
    memRvalid = 0;
    // store held 3 cycles without grant, late IF must not preempt
    lsReq = 1; lsWe = 1; lsBe = 4'b0011; lsAddr = 32'h40; lsWdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin ifReq = 1; ifAddr = 32'h300; end
      #1;
      chk("store_hold_be", memBe, 4'b0011);
      chk("store_hold_wdata", memWdata, 32'h1234_5678);
      chk("store_hold_ifGnt", ifGnt, 0);
      cyc();
    end
    memGnt = 1;
    #1;
    chk("store_lsGnt", lsGnt, 1);
    cyc();
    lsReq = 0; lsWe = 0; memGnt = 0; memRvalid = 1; memRdata = 32'h0;
    #1;
    chk("store_ack_ls", lsRvalid, 1);
    chk("store_ack_if", ifRvalid, 0);
    cyc();
    memRvalid = 0; memGnt = 1; cyc();
    ifReq = 0; memGnt = 0; memRvalid = 1; memRdata = 32'h3333_4444; cyc();
    memRvalid = 0;
    // starvation bound: LS saturates the port while IF waits
    ifReq = 1; ifAddr = 32'h500; lsReq = 1; lsAddr = 32'h600; lsBe = 4'hF; memGnt = 1;
    n_ls = 0; got_if = 0;
    for (int i = 0; i < 40 && !got_if; i++) begin
      memRvalid = pend;
      memRdata = $urandom;
      #1;
      if (lsGnt) n_ls++;
      if (ifGnt) got_if = 1;
      cyc();
    end
    chk("starve_ls_grants", 32'(n_ls), 32'd4);
    chk("starve_if_grant", {31'b0, got_if}, 32'd1);
    ifReq = 0; lsReq = 0; memGnt = 0; memRvalid = pend; cyc();
    memRvalid = 0;
    // spurious response while idle
    memRvalid = 1; memRdata = 32'hFFFF_0000;
    #1;
    chk("spur_ifRvalid", ifRvalid, 0);
    chk("spur_lsRvalid", lsRvalid, 0);
    cyc();
    memRvalid = 0; ifReq = 1; ifAddr = 32'h700;
    #1;
    chk("spur_still_idle", memReq, 1);
    memGnt = 1; cyc();
    ifReq = 0; memGnt = 0; memRvalid = 1; cyc();
    memRvalid = 0;
    // reset while waiting for a load, then a late response
    lsReq = 1; lsWe = 0; lsAddr = 32'h800; memGnt = 1; cyc();
    lsReq = 0; memGnt = 0; cyc();
    rst = 1; cyc();
    rst = 0; memRvalid = 1; memRdata = 32'hCAFE_0001;
    #1;
    chk("late_lsRvalid", lsRvalid, 0);
    chk("late_memReq", memReq, 0);
    cyc();
    memRvalid = 0; ifReq = 1; ifAddr = 32'h900;
    #1;
    chk("after_rst_idle", memReq, 1);
    memGnt = 1; cyc();
    ifReq = 0; memGnt = 0; memRvalid = 1; cyc();
    memRvalid = 0;
    // randomized traffic with compliant requesters and a random-latency memory
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 64) == 0;
      if (last_ifg || !ifReq) begin
        ifReq = (last_ifg ? ($urandom % 2) : ($urandom % 3 == 0));
        ifAddr = {$urandom} & 32'hFFFF_FFFC;
      end
      if (last_lsg || !lsReq) begin
        lsReq = (last_lsg ? ($urandom % 2) : ($urandom % 3 == 0));
        lsWe = $urandom % 2; lsBe = 4'($urandom); lsAddr = $urandom; lsWdata = $urandom;
      end
      memGnt = $urandom % 2;
      memRvalid = pend ? ($urandom % 2) : ($urandom % 8 == 0);
      memRdata = $urandom;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
